// File: rtl/fb_fetch.sv
// Framebuffer prefetch: sequential 16-bit PSRAM reads into a credit-limited FIFO drained by VGA pops.
// Define FB_FETCH_STATS_EN to build the saturating underrun event counter.
module fb_fetch #(
  parameter int          FIFO_DEPTH      = 16,
  parameter int          WORDS_PER_FRAME = 153600,
  parameter logic [25:0] BASE_ADDR       = 26'h0000000
) (
  input  logic        clk_100mhz,
  input  logic        n_reset,
  input  logic        frame_start_i,
  input  logic        pix_rd_i,
  output logic [15:0] pix_data_o,
  output logic        pix_valid_o,
  output logic        underrun_o,
  output logic [15:0] underrun_cnt_o,
  output logic        mem_cs_o,
  output logic        mem_rnw_o,
  output logic [25:0] mem_addr_o,
  input  logic [15:0] mem_rdata_i,
  input  logic        mem_ready_i
);

  localparam int          AW    = $clog2(FIFO_DEPTH);
  localparam logic [17:0] WPF   = 18'(WORDS_PER_FRAME);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DONE, DRAIN} state_t;
  state_t state, state_nxt;

  logic [15:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [17:0]   word_cnt;

  logic empty, free_ok, push, pop_ok, empty_pop, hold_cnt, clr_cnt;

  // cs high means one transaction is outstanding and already owns a FIFO slot
  assign empty     = (count == '0);
  assign free_ok   = (count + {{AW{1'b0}}, mem_cs_o}) < DEPTH;
  assign push      = (state == REQ) && mem_ready_i && !frame_start_i;
  assign pop_ok    = pix_rd_i && !empty && !frame_start_i;
  assign empty_pop = pix_rd_i && empty && !frame_start_i;
  // address must stay put while a transaction is still open, even across a restart
  assign hold_cnt  = mem_cs_o && !mem_ready_i;
  assign clr_cnt   = (frame_start_i || (state == DRAIN)) && !hold_cnt;

  assign mem_rnw_o  = 1'b1;
  assign mem_addr_o = BASE_ADDR + {8'b0, word_cnt};

  always_ff @(posedge clk_100mhz or negedge n_reset)
    if (!n_reset) state <= IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start_i)   state_nxt = IDLE;
               else if (word_cnt >= WPF) state_nxt = DONE;
               else if (free_ok)    state_nxt = REQ;
      REQ:     if (mem_ready_i)     state_nxt = IDLE;
               else if (frame_start_i) state_nxt = DRAIN;
      DRAIN:   if (mem_ready_i)     state_nxt = IDLE;
      DONE:    if (frame_start_i)   state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_cs_o = 1'b0;
    case (state)
      REQ, DRAIN: mem_cs_o = 1'b1;
      default:    mem_cs_o = 1'b0;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge n_reset)
    if (!n_reset)     word_cnt <= '0;
    else if (clr_cnt) word_cnt <= '0;
    else if (push)    word_cnt <= word_cnt + 18'd1;

  always_ff @(posedge clk_100mhz or negedge n_reset)
    if (!n_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (frame_start_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end

  always_ff @(posedge clk_100mhz)
    if (push) fifo_mem[wr_ptr] <= mem_rdata_i;

  always_ff @(posedge clk_100mhz or negedge n_reset)
    if (!n_reset) begin
      pix_data_o  <= '0;
      pix_valid_o <= 1'b0;
      underrun_o  <= 1'b0;
    end else begin
      pix_valid_o <= pop_ok;
      if (pix_rd_i) pix_data_o <= pop_ok ? fifo_mem[rd_ptr] : 16'h0000;
      if (frame_start_i)  underrun_o <= 1'b0;
      else if (empty_pop) underrun_o <= 1'b1;
    end

`ifdef FB_FETCH_STATS_EN
  always_ff @(posedge clk_100mhz or negedge n_reset)
    if (!n_reset)                                 underrun_cnt_o <= '0;
    else if (frame_start_i)                       underrun_cnt_o <= '0;
    else if (empty_pop && underrun_cnt_o != 16'hFFFF) underrun_cnt_o <= underrun_cnt_o + 16'd1;
`else
  assign underrun_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fb_fetch.sv
// Randomized bench for fb_fetch against a queue-based model of the fetch/FIFO/pop rules.
module tb_fb_fetch;
  localparam int          DEPTH = 16;
  localparam int          WPF   = 20;
  localparam logic [25:0] BASE  = 26'h0000000;

  logic        clk_100mhz = 1'b0, n_reset = 1'b0;
  logic        frame_start_i = 1'b0, pix_rd_i = 1'b0, mem_ready_i = 1'b0;
  logic [15:0] mem_rdata_i = '0, pix_data_o, underrun_cnt_o;
  logic        pix_valid_o, underrun_o, mem_cs_o, mem_rnw_o;
  logic [25:0] mem_addr_o;

  fb_fetch #(.FIFO_DEPTH(DEPTH), .WORDS_PER_FRAME(WPF), .BASE_ADDR(BASE)) dut (
    .clk_100mhz(clk_100mhz), .n_reset(n_reset), .frame_start_i(frame_start_i),
    .pix_rd_i(pix_rd_i), .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o),
    .underrun_o(underrun_o), .underrun_cnt_o(underrun_cnt_o), .mem_cs_o(mem_cs_o),
    .mem_rnw_o(mem_rnw_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .mem_ready_i(mem_ready_i));

  always #5 clk_100mhz = ~clk_100mhz;

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // reference model state: words the FIFO should hold, next expected word index, pop expectations
  logic [15:0] q[$];
  int          m_cnt, m_ucnt;
  bit          m_und, m_discard, e_valid;
  logic [15:0] e_data;
  // RAM responder / request monitor
  int          lat = 3, hi_cyc = 0, req_cnt = 0;
  bit          prev_cs = 0;
  logic [25:0] cur_addr = '0, last_addr = '0;
  logic [15:0] salt = '0;

  task automatic model_reset();
    q.delete();
    m_cnt = 0; m_ucnt = 0; m_und = 0; m_discard = 0;
    e_valid = 0; e_data = '0; hi_cyc = 0; prev_cs = 0;
  endtask

  task automatic cycle(input bit fs, input bit rd);
    bit rdy;
    @(negedge clk_100mhz);
    chk("pix_valid", 32'(pix_valid_o), 32'(e_valid));
    chk("pix_data", 32'(pix_data_o), 32'(e_data));
    chk("underrun", 32'(underrun_o), 32'(m_und));
`ifdef FB_FETCH_STATS_EN
    chk("underrun_cnt", 32'(underrun_cnt_o), 32'(m_ucnt));
`else
    chk("underrun_cnt", 32'(underrun_cnt_o), 32'(0));
`endif
    if (mem_cs_o && !prev_cs) begin
      req_cnt++;
      chk("req_addr", 32'(mem_addr_o), 32'(BASE + 26'(m_cnt)));
      chk("req_in_frame", 32'(m_cnt < WPF), 32'(1));
      chk("req_credit", 32'(q.size() < DEPTH), 32'(1));
      cur_addr = mem_addr_o; last_addr = mem_addr_o; hi_cyc = 0;
    end else if (mem_cs_o) begin
      chk("addr_stable", 32'(mem_addr_o), 32'(cur_addr));
    end
    prev_cs = mem_cs_o;
    rdy = 0;
    if (mem_cs_o) begin
      hi_cyc++;
      rdy = (hi_cyc >= lat);
    end
    mem_ready_i   = rdy;
    mem_rdata_i   = rdy ? (mem_addr_o[15:0] ^ salt) : 16'($urandom);
    frame_start_i = fs;
    pix_rd_i      = rd;
    // pop sees the FIFO before this edge's push; restart overrides everything
    if (rd) begin
      if (fs) begin e_valid = 0; e_data = '0; end
      else if (q.size() == 0) begin
        e_valid = 0; e_data = '0; m_und = 1;
        if (m_ucnt < 65535) m_ucnt++;
      end else begin e_valid = 1; e_data = q.pop_front(); end
    end else e_valid = 0;
    if (rdy) begin
      if (!m_discard && !fs) begin q.push_back(mem_rdata_i); m_cnt++; end
      m_discard = 0;
    end
    if (fs) begin
      q.delete(); m_und = 0; m_ucnt = 0; m_cnt = 0;
      if (mem_cs_o && !rdy) m_discard = 1;
    end
  endtask

  initial begin
    bit found;
    model_reset();
    #23;
    chk("rst_cs", 32'(mem_cs_o), 32'(0));
    chk("rst_rnw", 32'(mem_rnw_o), 32'(1));
    chk("rst_addr", 32'(mem_addr_o), 32'(BASE));
    chk("rst_valid", 32'(pix_valid_o), 32'(0));
    chk("rst_data", 32'(pix_data_o), 32'(0));
    chk("rst_und", 32'(underrun_o), 32'(0));
    chk("rst_ucnt", 32'(underrun_cnt_o), 32'(0));
    @(negedge clk_100mhz);
    n_reset = 1; frame_start_i = 1;

    // fill with no pops: exactly DEPTH requests then idle
    repeat (150) cycle(0, 0);
    chk("fill_reqs", 32'(req_cnt), 32'(DEPTH));
    chk("fill_last_addr", 32'(last_addr), 32'(BASE + 26'(DEPTH - 1)));
    chk("fill_cs_idle", 32'(mem_cs_o), 32'(0));

    // slow pops: each pop frees one credit until the frame's words are used up
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 1);
      repeat (3) cycle(0, 0);
    end
    chk("frame_reqs", 32'(req_cnt), 32'(WPF));
    chk("frame_last_addr", 32'(last_addr), 32'(BASE + 26'(WPF - 1)));

    // continuous pops run past the end of the frame into underrun
    repeat (25) cycle(0, 1);
    chk("done_und", 32'(underrun_o), 32'(1));
    chk("done_no_req", 32'(req_cnt), 32'(WPF));
    chk("done_cs", 32'(mem_cs_o), 32'(0));

    // restart with a simultaneous pop: flush wins, no underrun
    cycle(1, 1);
    salt = 16'($urandom);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      cycle(0, 0);
      if (mem_cs_o && mem_addr_o == BASE + 26'd7) found = 1;
    end
    chk("found_addr7", 32'(found), 32'(1));
    cycle(1, 0);
    cycle(0, 1);
    repeat (60) cycle(0, 0);
    repeat (12) cycle(0, 1);

    // long RAM latency with a pop every cycle
    cycle(1, 0);
    lat = 10;
    repeat (200) cycle(0, 1);
    chk("slow_und", 32'(underrun_o), 32'(1));
`ifdef FB_FETCH_STATS_EN
    for (int i = 0; i < 70000 && m_ucnt < 65535; i++) cycle(0, 1);
    repeat (5) cycle(0, 1);
    chk("ucnt_sat", 32'(underrun_cnt_o), 32'(16'hFFFF));
`endif

    // random traffic, restarts and latencies
    for (int i = 0; i < 3000; i++) begin
      if (!mem_cs_o && $urandom_range(0, 7) == 0) lat = $urandom_range(1, 6);
      if ($urandom_range(0, 40) == 0) salt = 16'($urandom);
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 1) == 1);
    end

    // async reset in the middle of a request
    cycle(1, 0);
    lat = 4;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      cycle(0, $urandom_range(0, 1) == 1);
      if (mem_cs_o && hi_cyc < lat - 1) found = 1;
    end
    chk("found_req", 32'(found), 32'(1));
    #2 n_reset = 0;
    mem_ready_i = 0; frame_start_i = 0; pix_rd_i = 0;
    #1;
    chk("mid_rst_cs", 32'(mem_cs_o), 32'(0));
    chk("mid_rst_addr", 32'(mem_addr_o), 32'(BASE));
    chk("mid_rst_valid", 32'(pix_valid_o), 32'(0));
    chk("mid_rst_data", 32'(pix_data_o), 32'(0));
    chk("mid_rst_und", 32'(underrun_o), 32'(0));
    chk("mid_rst_ucnt", 32'(underrun_cnt_o), 32'(0));
    @(negedge clk_100mhz);
    n_reset = 1;
    model_reset();
    lat = 2;
    repeat (60) cycle(0, 0);
    repeat (24) cycle(0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
